// File: rtl/alu_operand_loader_if.sv
// Bus bundle between the ALU operand loader and its surroundings.
// Holds the input word handshake, the ALU fragment drive/return
// signals, the result handshake, the completed-operation counter and a
// debug view of the loader state.
//
// Handshake rule shared by both channels: a transfer happens on a rising
// clk edge where valid && ready are both high. The producer keeps its
// payload stable while valid is high and ready is low. Neither ready nor
// valid is a combinational function of the opposite side's signal.
interface alu_operand_loader_if #(
  parameter int WIDTH = 8
);
  // input word stream (A, B, opcode)
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  // drive to / return from the selected ALU fragment
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic             alu_go;
  logic [WIDTH-1:0] alu_c;
  logic             alu_f;

  // result stream
  logic [WIDTH-1:0] res_c;
  logic             res_f;
  logic             res_err;
  logic             res_valid;
  logic             res_ready;

  // status
  logic [7:0]       op_cnt;
  logic [2:0]       dbg_state;

  // loader side
  modport slave (
    input  in_data, in_valid, alu_c, alu_f, res_ready,
    output in_ready, alu_a, alu_b, alu_op, alu_go,
           res_c, res_f, res_err, res_valid, op_cnt, dbg_state
  );

  // environment side (word source, fragment set, result sink)
  modport master (
    output in_data, in_valid, alu_c, alu_f, res_ready,
    input  in_ready, alu_a, alu_b, alu_op, alu_go,
           res_c, res_f, res_err, res_valid, op_cnt, dbg_state
  );
endinterface

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: serial front-end for the ALU fragment set.
// Collects operand A, operand B and an opcode word, drives them to the
// fragments for one EXEC cycle, captures the fragment C/F outputs and
// offers them on a result handshake, counting completed operations.
//
// Optional feature macro: DIV_ZERO_CHK_EN
//   defined   -> DIV (opcode 9) with B == 0 is intercepted: alu_go stays
//                low and the result is all-ones C, F=1, err=1.
//   undefined -> DIV by zero is passed through like any other opcode.
//
// State is exported on bus.dbg_state (S_A=0, S_B=1, S_OP=2, S_EXEC=3,
// S_OUT=4).
module alu_operand_loader #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  alu_operand_loader_if.slave bus
);

  localparam logic [3:0] OP_DIV      = 4'd9;
  localparam logic [3:0] OP_LAST_LEG = 4'd10;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_op;
  logic [WIDTH-1:0] r_res_c;
  logic             r_res_f;
  logic             r_res_err;
  logic [7:0]       r_op_cnt;

  logic             w_in_ready;
  logic             w_alu_go;
  logic             w_res_valid;
  logic             w_in_fire;
  logic             w_res_fire;
  logic             w_legal_op;
  logic             w_div_zero;
  logic             w_unused_opword;

  // Transfers on each channel.
  assign w_in_fire  = bus.in_valid  && w_in_ready;
  assign w_res_fire = bus.res_ready && w_res_valid;

  // Opcodes 0..10 select a fragment; 11..15 are rejected.
  assign w_legal_op = (r_alu_op <= OP_LAST_LEG);

`ifdef DIV_ZERO_CHK_EN
  assign w_div_zero = (r_alu_op == OP_DIV) && (r_alu_b == '0);
`else
  assign w_div_zero = 1'b0;
`endif

  // Only the low nibble of the opcode word is meaningful.
  assign w_unused_opword = ^bus.in_data[WIDTH-1:4];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_A;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: three input beats, one EXEC cycle, then hold in
  // S_OUT until the consumer takes the result.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_A:     if (bus.in_valid)  w_next_state = S_B;
      S_B:     if (bus.in_valid)  w_next_state = S_OP;
      S_OP:    if (bus.in_valid)  w_next_state = S_EXEC;
      S_EXEC:                     w_next_state = S_OUT;
      S_OUT:   if (bus.res_ready) w_next_state = S_A;
      default:                    w_next_state = S_A;
    endcase
  end

  // Output decode from the state alone (plus the div-by-zero guard on
  // alu_go, which looks at registered operands only).
  always_comb begin
    w_in_ready  = 1'b0;
    w_alu_go    = 1'b0;
    w_res_valid = 1'b0;
    case (r_state)
      S_A, S_B, S_OP: w_in_ready  = 1'b1;
      S_EXEC:         w_alu_go    = !w_div_zero;
      S_OUT:          w_res_valid = 1'b1;
      default: begin
        w_in_ready  = 1'b0;
        w_alu_go    = 1'b0;
        w_res_valid = 1'b0;
      end
    endcase
  end

  // Operand A register: loaded by the first beat of a transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a <= '0;
    end else if (w_in_fire && (r_state == S_A)) begin
      r_alu_a <= bus.in_data;
    end
  end

  // Operand B register: loaded by the second beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_b <= '0;
    end else if (w_in_fire && (r_state == S_B)) begin
      r_alu_b <= bus.in_data;
    end
  end

  // Opcode register: low nibble of the third beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_op <= '0;
    end else if (w_in_fire && (r_state == S_OP)) begin
      r_alu_op <= bus.in_data[3:0];
    end
  end

  // Result capture at the end of EXEC; held unchanged through S_OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_c   <= '0;
      r_res_f   <= 1'b0;
      r_res_err <= 1'b0;
    end else if (r_state == S_EXEC) begin
      if (w_div_zero) begin
        r_res_c   <= '1;
        r_res_f   <= 1'b1;
        r_res_err <= 1'b1;
      end else if (w_legal_op) begin
        r_res_c   <= bus.alu_c;
        r_res_f   <= bus.alu_f;
        r_res_err <= 1'b0;
      end else begin
        r_res_c   <= '0;
        r_res_f   <= 1'b0;
        r_res_err <= 1'b1;
      end
    end
  end

  // Completed-operation counter; wraps naturally at 8 bits and counts
  // error transactions too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_cnt <= '0;
    end else if (w_res_fire) begin
      r_op_cnt <= r_op_cnt + 8'd1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_op    = r_alu_op;
  assign bus.alu_go    = w_alu_go;
  assign bus.res_c     = r_res_c;
  assign bus.res_f     = r_res_f;
  assign bus.res_err   = r_res_err;
  assign bus.res_valid = w_res_valid;
  assign bus.op_cnt    = r_op_cnt;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Bench for alu_operand_loader: drives word beats with random gaps and
// random res_ready back-pressure, models the ALU fragment set, and
// compares every DUT output each cycle against a transaction-level model.
module tb_alu_operand_loader;
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_operand_loader_if #(.WIDTH(W)) bus ();

  alu_operand_loader #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- ALU fragment set ----------------
  // Returns {F, C} for one opcode.
  function automatic logic [8:0] frag(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [15:0] p;
    case (op)
      4'd0:  return {1'b0, a | b};
      4'd1:  return {1'b0, a & b};
      4'd2:  return {1'b0, ~a};
      4'd3:  return {1'b0, a ^ b};
      4'd4:  return {a, 1'b0};
      4'd5:  return {2'b00, a[7:1]};
      4'd6:  return {1'b0, a} + {1'b0, b};
      4'd7:  return {(a < b), 8'(a - b)};
      4'd8:  begin p = {8'd0, a} * {8'd0, b}; return p[8:0]; end
      4'd9:  return (b == 8'd0) ? 9'h0FF : {1'b0, 8'(a / b)};
      4'd10: return {1'b0, 8'(~a + 8'd1)};
      default: return 9'h000;
    endcase
  endfunction

  always_comb begin
    {bus.alu_f, bus.alu_c} = frag(bus.alu_a, bus.alu_b, bus.alu_op);
  end

  function automatic bit div0_special(input logic [7:0] b, input logic [3:0] op);
`ifdef DIV_ZERO_CHK_EN
    return (op == 4'd9) && (b == 8'd0);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- behavioural model ----------------
  logic [W-1:0] exp_q[$];     // words collected for the current transaction
  bit           m_exec, m_out;
  logic [7:0]   m_a, m_b;
  logic [3:0]   m_op;
  logic [7:0]   m_c;
  logic         m_f, m_err;
  int           m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_exec = 0; m_out = 0;
      m_a = 0; m_b = 0; m_op = 0;
      m_c = 0; m_f = 0; m_err = 0; m_cnt = 0;
    end else if (m_out) begin
      if (bus.res_ready) begin
        m_out = 0;
        m_cnt = (m_cnt + 1) % 256;
      end
    end else if (m_exec) begin
      if (exp_q[2][3:0] > 4'd10) begin
        m_c = 0; m_f = 0; m_err = 1;
      end else if (div0_special(exp_q[1], exp_q[2][3:0])) begin
        m_c = 8'hFF; m_f = 1; m_err = 1;
      end else begin
        {m_f, m_c} = frag(exp_q[0], exp_q[1], exp_q[2][3:0]);
        m_err = 0;
      end
      exp_q.delete();
      m_exec = 0;
      m_out  = 1;
    end else if (bus.in_valid) begin
      if (exp_q.size() == 0) m_a = bus.in_data;
      else if (exp_q.size() == 1) m_b = bus.in_data;
      else m_op = bus.in_data[3:0];
      exp_q.push_back(bus.in_data);
      if (exp_q.size() == 3) m_exec = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("in_ready",  32'(bus.in_ready),  32'(!(m_exec || m_out)));
    check("alu_go",    32'(bus.alu_go),    32'(m_exec && !div0_special(m_b, m_op)));
    check("res_valid", 32'(bus.res_valid), 32'(m_out));
    check("alu_a",     32'(bus.alu_a),     32'(m_a));
    check("alu_b",     32'(bus.alu_b),     32'(m_b));
    check("alu_op",    32'(bus.alu_op),    32'(m_op));
    check("op_cnt",    32'(bus.op_cnt),    32'(m_cnt));
    if (m_out) begin
      check("res_c",   32'(bus.res_c),   32'(m_c));
      check("res_f",   32'(bus.res_f),   32'(m_f));
      check("res_err", 32'(bus.res_err), 32'(m_err));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [W-1:0] w, input int max_gap);
    int gap;
    int waited;
    bit rdy;
    gap = $urandom_range(max_gap, 0);
    for (int i = 0; i < gap; i++) begin
      bus.in_valid  = 1'b0;
      bus.in_data   = W'($urandom);
      bus.res_ready = 1'($urandom_range(1, 0));
      @(posedge clk); #2;
    end
    bus.in_data   = w;
    bus.in_valid  = 1'b1;
    bus.res_ready = 1'($urandom_range(1, 0));
    waited = 0;
    forever begin
      rdy = bus.in_ready;
      @(posedge clk); #2;
      if (rdy) break;
      waited++;
      if (waited > 50) begin
        fail_now("send_word_timeout");
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] opw,
                         input int max_gap, input int bp,
                         output logic [W-1:0] c, output logic f, output logic err,
                         output int edges, output bit go_seen);
    send_word(a, max_gap);
    send_word(b, max_gap);
    send_word(opw, max_gap);
    go_seen       = bus.alu_go;
    bus.res_ready = (bp == 0);
    bus.in_valid  = 1'($urandom_range(1, 0));
    bus.in_data   = W'($urandom);
    edges = 0;
    while (!bus.res_valid && edges < 20) begin
      @(posedge clk); #2;
      edges++;
      if (bus.alu_go) go_seen = 1;
    end
    if (!bus.res_valid) fail_now("res_valid_timeout");
    c = bus.res_c; f = bus.res_f; err = bus.res_err;
    for (int i = 0; i < bp; i++) begin
      bus.in_valid = 1'($urandom_range(1, 0));
      bus.in_data  = W'($urandom);
      @(posedge clk); #2;
      check("bp_held_c",   32'(bus.res_c),     32'(c));
      check("bp_held_f",   32'(bus.res_f),     32'(f));
      check("bp_held_err", 32'(bus.res_err),   32'(err));
      check("bp_valid",    32'(bus.res_valid), 32'd1);
      check("bp_in_ready", 32'(bus.in_ready),  32'd0);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); #2;
    bus.res_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check("res_valid_drop", 32'(bus.res_valid), 32'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [W-1:0] c;
    logic f, e;
    int edges;
    bit go;

    bus.in_data = '0; bus.in_valid = 1'b0; bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_alu_go",    32'(bus.alu_go),    32'd0);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_alu_a",     32'(bus.alu_a),     32'd0);
    check("rst_res_err",   32'(bus.res_err),   32'd0);
    check("rst_op_cnt",    32'(bus.op_cnt),    32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // basic add, consumer ready; result one edge after the opcode edge
    run_txn(8'h0F, 8'h01, 8'h06, 0, 0, c, f, e, edges, go);
    check("add_c",   32'(c), 32'h10);
    check("add_f",   32'(f), 32'd0);
    check("add_err", 32'(e), 32'd0);
    check("add_latency", 32'(edges), 32'd1);
    check("add_go",  32'(go), 32'd1);
    check("add_cnt", 32'(bus.op_cnt), 32'd1);

    // carry out with 10 cycles of back-pressure
    run_txn(8'hFF, 8'h01, 8'h06, 2, 10, c, f, e, edges, go);
    check("carry_c",   32'(c), 32'h00);
    check("carry_f",   32'(f), 32'd1);
    check("carry_err", 32'(e), 32'd0);

    // illegal opcode
    run_txn(8'h12, 8'h34, 8'h0C, 1, 1, c, f, e, edges, go);
    check("ill_c",   32'(c), 32'h00);
    check("ill_f",   32'(f), 32'd0);
    check("ill_err", 32'(e), 32'd1);
    check("ill_cnt", 32'(bus.op_cnt), 32'd3);

    // upper opcode bits ignored: 0xA7 is SUB, 5-3=2
    run_txn(8'h05, 8'h03, 8'hA7, 1, 0, c, f, e, edges, go);
    check("sub_c", 32'(c), 32'h02);
    check("sub_f", 32'(f), 32'd0);

    // divide by zero
    run_txn(8'h20, 8'h00, 8'h09, 0, 2, c, f, e, edges, go);
`ifdef DIV_ZERO_CHK_EN
    check("div0_go",  32'(go), 32'd0);
    check("div0_c",   32'(c),  32'hFF);
    check("div0_f",   32'(f),  32'd1);
    check("div0_err", 32'(e),  32'd1);
`else
    check("div0_go",  32'(go), 32'd1);
    check("div0_err", 32'(e),  32'd0);
`endif

    // reset in the middle of a transaction
    send_word(8'hAA, 0);
    send_word(8'h55, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_alu_a",   32'(bus.alu_a),    32'd0);
    check("mid_rst_alu_b",   32'(bus.alu_b),    32'd0);
    check("mid_rst_op_cnt",  32'(bus.op_cnt),   32'd0);
    check("mid_rst_in_rdy",  32'(bus.in_ready), 32'd1);
    check("mid_rst_res_c",   32'(bus.res_c),    32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    run_txn(8'h03, 8'h04, 8'h07, 0, 0, c, f, e, edges, go);
    check("post_rst_c",   32'(c), 32'hFF);
    check("post_rst_f",   32'(f), 32'd1);
    check("post_rst_cnt", 32'(bus.op_cnt), 32'd1);

    // random traffic; 255 more transactions bring the counter back to 0
    for (int t = 0; t < 255; t++) begin
      logic [W-1:0] ra, rb, ro;
      ra = W'($urandom);
      rb = ($urandom_range(7, 0) == 0) ? 8'h00 : W'($urandom);
      ro = {4'($urandom), 4'($urandom_range(15, 0))};
      if ($urandom_range(3, 0) == 0) ro[3:0] = 4'd9;
      run_txn(ra, rb, ro, 2, $urandom_range(3, 0), c, f, e, edges, go);
    end
    check("wrap_cnt", 32'(bus.op_cnt), 32'd0);

    @(posedge clk); #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // global time bound
  initial begin
    #2000000;
    fail_now("global_watchdog");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
